// File: rtl/burst_mem_bridge.sv
// burst_mem_bridge: splits cache block-burst requests into single-word
// request/acknowledge transactions on the main memory bus, with a per-word
// acknowledge timeout that aborts the burst and raises a sticky error.
module burst_mem_bridge #(
  parameter int unsigned MAX_BURST = 32,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        burst_en,
  input  logic [7:0]  burst_length,
  input  logic [31:0] up_a,
  input  logic [31:0] up_d,
  input  logic        up_we,
  input  logic        up_rd,
  output logic [31:0] up_spo,
  output logic        up_ready,
  output logic        busy,
  output logic        err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [31:0] mem_spo,
  input  logic        mem_ready
);

  localparam int unsigned LW = 8;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic          dir_q, dir_nx;
  logic [LW-1:0] len_q, len_nx;
  logic [LW-1:0] cnt_q, cnt_nx;
  logic [TW-1:0] tmo_q, tmo_nx;
  logic [31:0]   a_nx, d_nx, spo_nx;
  logic          err_nx, up_ready_nx, busy_nx, mem_rd_nx, mem_we_nx;

  logic          req_c, timeout_c, last_c;
  logic [LW-1:0] len_req_c;
  logic          unused_addr_lsb_c;

  assign unused_addr_lsb_c = ^up_a[1:0];

  assign req_c     = up_rd | up_we;
  assign timeout_c = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
  assign last_c    = (cnt_q + LW'(1)) == len_q;

  // Requested length, out-of-range burst lengths collapse to a single word
  always_comb begin
    len_req_c = LW'(1);
    if (burst_en && (burst_length != '0) && (32'(burst_length) <= MAX_BURST))
      len_req_c = burst_length;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_c) state_nx = up_we ? LATCH : ISSUE;
      LATCH:   state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT: begin
        if (mem_ready)      state_nx = RESP;
        else if (timeout_c) state_nx = IDLE;
      end
      RESP: begin
        if (last_c)     state_nx = IDLE;
        else if (dir_q) state_nx = LATCH;
        else            state_nx = ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output and datapath next values; strobes decode from the next state
  always_comb begin
    dir_nx = dir_q;
    len_nx = len_q;
    cnt_nx = cnt_q;
    tmo_nx = tmo_q;
    a_nx   = mem_a;
    d_nx   = mem_d;
    spo_nx = up_spo;
    err_nx = err;
    case (state)
      IDLE: begin
        if (req_c) begin
          a_nx   = {up_a[31:2], 2'b00};
          dir_nx = up_we;
          len_nx = len_req_c;
          cnt_nx = '0;
        end
      end
      LATCH: d_nx = up_d;
      ISSUE: tmo_nx = '0;
      WAIT: begin
        if (mem_ready) begin
          if (!dir_q) spo_nx = mem_spo;
        end else if (timeout_c) begin
          err_nx = 1'b1;
        end else begin
          tmo_nx = tmo_q + TW'(1);
        end
      end
      RESP: begin
        cnt_nx = cnt_q + LW'(1);
        a_nx   = mem_a + 32'd4;
      end
      default: ;
    endcase
    up_ready_nx = (state_nx == RESP);
    busy_nx     = (state_nx != IDLE);
    mem_rd_nx   = (state_nx == ISSUE) && !dir_nx;
    mem_we_nx   = (state_nx == ISSUE) && dir_nx;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q    <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      mem_a    <= '0;
      mem_d    <= '0;
      up_spo   <= '0;
      err      <= 1'b0;
      up_ready <= 1'b0;
      busy     <= 1'b0;
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      dir_q    <= dir_nx;
      len_q    <= len_nx;
      cnt_q    <= cnt_nx;
      tmo_q    <= tmo_nx;
      mem_a    <= a_nx;
      mem_d    <= d_nx;
      up_spo   <= spo_nx;
      err      <= err_nx;
      up_ready <= up_ready_nx;
      busy     <= busy_nx;
      mem_rd   <= mem_rd_nx;
      mem_we   <= mem_we_nx;
    end
  end

endmodule

// File: tb/tb_burst_mem_bridge.sv
// tb_burst_mem_bridge: directed bursts against a latency-programmable memory
// model; expected memory requests and upstream completions are queued by the
// stimulus and consumed by an independent monitor.
module tb_burst_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        burst_en = 1'b0;
  logic [7:0]  burst_length = '0;
  logic [31:0] up_a = '0;
  logic [31:0] up_d = '0;
  logic        up_we = 1'b0;
  logic        up_rd = 1'b0;
  logic [31:0] up_spo;
  logic        up_ready;
  logic        busy;
  logic        err;
  logic [31:0] mem_a;
  logic [31:0] mem_d;
  logic        mem_we;
  logic        mem_rd;
  logic [31:0] mem_spo = '0;
  logic        mem_ready = 1'b0;

  burst_mem_bridge #(.MAX_BURST(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .burst_en(burst_en), .burst_length(burst_length),
    .up_a(up_a), .up_d(up_d), .up_we(up_we), .up_rd(up_rd),
    .up_spo(up_spo), .up_ready(up_ready), .busy(busy), .err(err),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_spo(mem_spo), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [31:0] a; logic [31:0] d;} mem_exp_t;
  typedef struct {logic [31:0] spo; logic is_rd; int gap; logic last;} up_exp_t;

  mem_exp_t exp_mem[$];
  up_exp_t  exp_up[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory model controls
  int   lat = 1;
  int   drop_idx = -1;
  int   req_idx = 0;
  int   force_n = 0;
  int   force_seen = 0;
  logic spur_en = 1'b0;
  int   cd = 0;
  logic [31:0] pend_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: acknowledges each request lat cycles later with data = address
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin mem_ready = 1'b1; mem_spo = pend_a; end
    end
    if (force_seen != force_n) begin
      force_seen = force_n;
      mem_ready = 1'b1;
      mem_spo = 32'hBAD0_0000;
    end
    if (spur_en && up_ready) begin mem_ready = 1'b1; mem_spo = 32'hDEAD_BEEF; end
    if (!rst && (mem_rd || mem_we)) begin
      if (req_idx != drop_idx) begin cd = lat; pend_a = mem_a; end
      req_idx++;
    end
  end

  // Monitor: consumes expected entries whenever the DUT presents a strobe
  mem_exp_t m;
  up_exp_t  u;
  int       last_up = 0;
  logic     chk_fall = 1'b0;
  always @(negedge clk) begin
    if (chk_fall) begin chk("busy_fall", 32'(busy), 32'd0); chk_fall = 1'b0; end
    if (!rst) begin
      if (mem_rd || mem_we) begin
        chk("mem_expected", 32'(exp_mem.size() != 0), 32'd1);
        chk("mem_one_dir", 32'(mem_rd & mem_we), 32'd0);
        if (exp_mem.size() != 0) begin
          m = exp_mem.pop_front();
          chk("mem_we", 32'(mem_we), 32'(m.we));
          chk("mem_a", mem_a, m.a);
          if (m.we) chk("mem_d", mem_d, m.d);
        end
      end
      if (up_ready) begin
        chk("up_expected", 32'(exp_up.size() != 0), 32'd1);
        if (exp_up.size() != 0) begin
          u = exp_up.pop_front();
          if (u.is_rd) chk("up_spo", up_spo, u.spo);
          if (u.gap != 0) chk("up_gap", 32'(cyc - last_up), 32'(u.gap));
          if (u.last) chk_fall = 1'b1;
        end
        last_up = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic we, input logic [31:0] base, input int n, input int l);
    for (int i = 0; i < n; i++) begin
      exp_mem.push_back('{we, base + 32'(4 * i), 32'hA0 + 32'(i)});
      exp_up.push_back('{base + 32'(4 * i), !we, (i == 0) ? 0 : (we ? l + 3 : l + 2), i == n - 1});
    end
  endtask

  task automatic req(input logic rd, input logic we, input logic en, input logic [7:0] bl,
                     input logic [31:0] a);
    up_rd = rd; up_we = we; burst_en = en; burst_length = bl; up_a = a;
    tick();
    up_rd = 1'b0; up_we = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    chk({name, "_idle"}, 32'(busy), 32'd0);
    tick(); tick();
    chk({name, "_up_left"}, 32'(exp_up.size()), 32'd0);
    chk({name, "_mem_left"}, 32'(exp_mem.size()), 32'd0);
  endtask

  task automatic wait_pulses(input int want);
    int k = 0;
    int n = 0;
    while (k < want && n < 500) begin
      if (up_ready) k++;
      if (k < want) tick();
      n++;
    end
    chk("pulse_wait", 32'(k), 32'(want));
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_up_spo"}, up_spo, 32'd0);
    chk({name, "_up_ready"}, 32'(up_ready), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
    chk({name, "_mem_a"}, mem_a, 32'd0);
    chk({name, "_mem_d"}, mem_d, 32'd0);
    chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({name, "_mem_rd"}, 32'(mem_rd), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    tick(); tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // 32-word read, address bits [1:0] dropped
    lat = 1;
    push_burst(1'b0, 32'h1000_0040, 32, 1);
    req(1'b1, 1'b0, 1'b1, 8'd32, 32'h1000_0042);
    wait_idle("rd32", 300);

    // 4-word write, both request lines high, data advanced per completion
    lat = 3;
    push_burst(1'b1, 32'h0000_0040, 4, 3);
    up_d = 32'hA0;
    req(1'b1, 1'b1, 1'b1, 8'd4, 32'h0000_0040);
    for (int k = 1; k < 4; k++) begin
      wait_pulses(1);
      up_d = 32'hA0 + 32'(k);
      tick();
    end
    wait_idle("wr4", 100);

    // single transfers: burst_en=0, length 0, length above MAX_BURST
    lat = 1;
    push_burst(1'b0, 32'h0000_0100, 1, 1);
    req(1'b1, 1'b0, 1'b0, 8'd32, 32'h0000_0100);
    wait_idle("single_en0", 20);
    push_burst(1'b0, 32'h0000_0200, 1, 1);
    req(1'b1, 1'b0, 1'b1, 8'd0, 32'h0000_0200);
    wait_idle("single_len0", 20);
    push_burst(1'b0, 32'h0000_0300, 1, 1);
    req(1'b1, 1'b0, 1'b1, 8'd33, 32'h0000_0300);
    wait_idle("single_len33", 20);

    // requests while busy and mem_ready during RESP are ignored
    lat = 2;
    spur_en = 1'b1;
    push_burst(1'b0, 32'h0000_2000, 4, 2);
    req(1'b1, 1'b0, 1'b1, 8'd4, 32'h0000_2000);
    tick(); tick(); tick();
    up_rd = 1'b1; up_a = 32'h0000_9000; burst_length = 8'd8;
    tick();
    up_rd = 1'b0; up_we = 1'b1;
    tick();
    up_we = 1'b0;
    wait_idle("spurious", 100);
    spur_en = 1'b0;

    // word 2 never acknowledged: timeout after 15 WAIT cycles
    lat = 1;
    drop_idx = req_idx + 2;
    push_burst(1'b0, 32'h0000_3000, 3, 1);
    void'(exp_up.pop_back());
    req(1'b1, 1'b0, 1'b1, 8'd4, 32'h0000_3000);
    wait_pulses(2);
    tick();
    n = 0;
    while (!mem_rd && n < 20) begin tick(); n++; end
    t0 = cyc;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("timeout_len", 32'(cyc - t0), 32'd16);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_up_left", 32'(exp_up.size()), 32'd0);
    chk("timeout_mem_left", 32'(exp_mem.size()), 32'd0);
    force_n++;
    for (int i = 0; i < 6; i++) tick();
    chk("late_ack_err", 32'(err), 32'd1);
    chk("late_ack_busy", 32'(busy), 32'd0);
    drop_idx = -1;

    // reset while waiting on word 5, then a clean burst
    lat = 3;
    push_burst(1'b0, 32'h0000_4000, 8, 3);
    req(1'b1, 1'b0, 1'b1, 8'd8, 32'h0000_4000);
    wait_pulses(5);
    tick();
    chk("rst_word5_issue", 32'(mem_rd), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_zero_outputs("midrst");
    chk("midrst_up_left", 32'(exp_up.size()), 32'd3);
    chk("midrst_mem_left", 32'(exp_mem.size()), 32'd2);
    exp_up.delete();
    exp_mem.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    lat = 1;
    push_burst(1'b0, 32'h0000_5000, 3, 1);
    req(1'b1, 1'b0, 1'b1, 8'd3, 32'h0000_5000);
    wait_idle("post_rst", 50);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
